alpaca_multadd_axis_pipe: RTL

Parametrised fixed-point multiply-add, a*b + c, with AXI-Stream slave and master ports and full backpressure.
Computes the result at full precision, then requantises it to a configurable output format with optional rounding and saturation.
Sideband data (tlast, tuser) travels with each beat.
Successor to the bare alpaca_multadd; used in the PFB phase MAC chain wherever the downstream consumer can stall.

---
 rtl/alpaca_multadd_axis_pipe.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alpaca_multadd_axis_pipe.sv
// AXI-Stream a*b + c with full-precision accumulate and requantisation to OUT_W/OUT_F.
// Define ALPACA_MULTADD_SAT_EN to clamp overflowing results instead of wrapping.
module alpaca_multadd_axis_pipe #(
  parameter int W      = 16,
  parameter int F      = 15,
  parameter int OUT_W  = 16,
  parameter int OUT_F  = 15,
  parameter int LAT    = 5,
  parameter int ROUND  = 1,
  parameter int USER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] s_axis_a,
  input  logic signed [W-1:0] s_axis_b,
  input  logic signed [W-1:0] s_axis_c,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic [USER_W-1:0]   s_axis_tuser,
  output logic [OUT_W-1:0]    m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [USER_W-1:0]   m_axis_tuser,
  output logic                m_axis_tovf,
  output logic                ovf_sticky
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;
  localparam int RW = 2 * W + 2;
  localparam int SH = 2 * F - OUT_F;
  localparam int NR = LAT - 3;
  localparam int XW = USER_W + 1;

  function automatic logic signed [RW-1:0] rnd_const();
    if (ROUND != 0 && SH > 0) return RW'(1) <<< (SH - 1);
    return '0;
  endfunction

  localparam logic signed [RW-1:0] RND  = rnd_const();
  localparam logic signed [RW-1:0] OMAX = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] OMIN = -(RW'(1) <<< (OUT_W - 1));

  // Widening to RW bits first keeps the rounding addition from wrapping.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] s);
    logic signed [RW-1:0] sx;
    sx = RW'(s) + RND;
    return sx >>> SH;
  endfunction

  function automatic logic is_ovf(input logic signed [RW-1:0] r);
    return (r > OMAX) || (r < OMIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] requant(input logic signed [RW-1:0] r);
`ifdef ALPACA_MULTADD_SAT_EN
    if (is_ovf(r)) return r[RW-1] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0];
`endif
    return r[OUT_W-1:0];
  endfunction

  logic en;
  logic acc;

  logic signed [W-1:0]     a_p1_q, b_p1_q, c_p1_q, c_p2_q;
  logic signed [PW-1:0]    prod_p2_q, prod_p2_d;
  logic signed [SW-1:0]    sum_p3_q, sum_p3_d;
  logic signed [RW-1:0]    r_p4_d;
  logic signed [OUT_W-1:0] res_p4_q, res_p4_d;
  logic                    ovf_p4_q, ovf_p4_d;
  logic                    vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic [XW-1:0]           side_p1_q, side_p2_q, side_p3_q, side_p4_q;

  logic signed [OUT_W-1:0] res_rt_q [NR];
  logic signed [OUT_W-1:0] res_rt_d [NR];
  logic                    ovf_rt_q [NR];
  logic                    ovf_rt_d [NR];
  logic                    vld_rt_q [NR];
  logic                    vld_rt_d [NR];
  logic [XW-1:0]           side_rt_q [NR];
  logic [XW-1:0]           side_rt_d [NR];

  logic ovf_sticky_q, ovf_sticky_d;

  // A stalled output freezes the whole pipe, so ready depends combinationally on m_axis_tready.
  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en && !rst;
  assign acc           = s_axis_tvalid && s_axis_tready;

  always_comb begin
    prod_p2_d = PW'(a_p1_q) * PW'(b_p1_q);
    sum_p3_d  = SW'(prod_p2_q) + (SW'(c_p2_q) <<< F);
    r_p4_d    = round_shift(sum_p3_q);
    res_p4_d  = requant(r_p4_d);
    ovf_p4_d  = is_ovf(r_p4_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= acc;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      // p1: input capture
      a_p1_q    <= s_axis_a;
      b_p1_q    <= s_axis_b;
      c_p1_q    <= s_axis_c;
      side_p1_q <= {s_axis_tlast, s_axis_tuser};
      // p2: full-precision product
      prod_p2_q <= prod_p2_d;
      c_p2_q    <= c_p1_q;
      side_p2_q <= side_p1_q;
      // p3: aligned sum
      sum_p3_q  <= sum_p3_d;
      side_p3_q <= side_p2_q;
      // p4: requantised result
      res_p4_q  <= res_p4_d;
      ovf_p4_q  <= ovf_p4_d;
      side_p4_q <= side_p3_q;
    end
  end

  // Retiming stages; the last one drives m_axis_* and is fully reset.
  for (genvar i = 0; i < NR; i++) begin : g_rt
    if (i == 0) begin : g_head
      assign res_rt_d[i]  = res_p4_q;
      assign ovf_rt_d[i]  = ovf_p4_q;
      assign vld_rt_d[i]  = vld_p4_q;
      assign side_rt_d[i] = side_p4_q;
    end else begin : g_tail
      assign res_rt_d[i]  = res_rt_q[i-1];
      assign ovf_rt_d[i]  = ovf_rt_q[i-1];
      assign vld_rt_d[i]  = vld_rt_q[i-1];
      assign side_rt_d[i] = side_rt_q[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst)     vld_rt_q[i] <= 1'b0;
      else if (en) vld_rt_q[i] <= vld_rt_d[i];
    end

    if (i == NR - 1) begin : g_out
      always_ff @(posedge clk) begin
        if (rst) begin
          res_rt_q[i]  <= '0;
          ovf_rt_q[i]  <= 1'b0;
          side_rt_q[i] <= '0;
        end else if (en) begin
          res_rt_q[i]  <= res_rt_d[i];
          ovf_rt_q[i]  <= ovf_rt_d[i];
          side_rt_q[i] <= side_rt_d[i];
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (en) begin
          res_rt_q[i]  <= res_rt_d[i];
          ovf_rt_q[i]  <= ovf_rt_d[i];
          side_rt_q[i] <= side_rt_d[i];
        end
      end
    end
  end

  assign ovf_sticky_d = ovf_sticky_q || (m_axis_tvalid && m_axis_tready && m_axis_tovf);

  always_ff @(posedge clk) begin
    if (rst) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  assign m_axis_tdata  = res_rt_q[NR-1];
  assign m_axis_tvalid = vld_rt_q[NR-1];
  assign m_axis_tovf   = ovf_rt_q[NR-1];
  assign m_axis_tlast  = side_rt_q[NR-1][USER_W];
  assign m_axis_tuser  = side_rt_q[NR-1][USER_W-1:0];
  assign ovf_sticky    = ovf_sticky_q;

endmodule
